// File: rtl/axis_band_source_pkg.sv
// Shared types and default sizing for the band source and its buffer.
package axis_band_source_pkg;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_STALL_LIMIT = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } bandState_e;

endpackage

// File: rtl/axis_band_fifo.sv
// Synchronous FIFO with a registered head word (first-word fall-through).
// A written word lands in memory first and reaches the head register one edge
// later, so the head is always a flop and never a bypass of the write data.
module axis_band_fifo
   import axis_band_source_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + 1,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] headData_o,
   output logic             headValid_o,
   output logic             memNonEmpty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [CW-1:0]    memCnt_q;
   logic [WIDTH-1:0] head_q;
   logic             headValid_q;

   logic             popHead;
   logic             fill;
   logic             wrEn;
   logic [CW-1:0]    totalCnt;

   assign popHead  = pop_i & headValid_q;
   assign fill     = (memCnt_q != '0) & (~headValid_q | popHead);
   assign totalCnt = memCnt_q + {{(CW-1){1'b0}}, headValid_q};
   assign full_o   = (totalCnt == CW'(DEPTH));
   assign wrEn     = push_i & (~full_o | popHead);

   assign headData_o    = head_q;
   assign headValid_o   = headValid_q;
   assign memNonEmpty_o = (memCnt_q != '0);

   // Pointer, occupancy and head-register bookkeeping; reset empties the buffer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         memCnt_q    <= '0;
         head_q      <= '0;
         headValid_q <= 1'b0;
      end else begin
         if (wrEn) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (fill) begin
            rdPtr_q <= rdPtr_q + 1'b1;
            head_q  <= mem_q[rdPtr_q];
         end
         headValid_q <= fill | (headValid_q & ~popHead);
         memCnt_q    <= memCnt_q + CW'(wrEn) - CW'(fill);
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

endmodule

// File: rtl/axis_band_source.sv
// AXI-Stream band source: buffers loaded beats and replays them with a
// programmable idle gap after each beat, counting beats/bands and flagging
// prolonged backpressure.
module axis_band_source
   import axis_band_source_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic [3:0]        gap,
   output logic              out_stream_TVALID,
   input  logic              out_stream_TREADY,
   output logic [DATA_W-1:0] out_stream_TDATA,
   output logic              out_stream_TLAST,
   output logic [31:0]       beat_cnt,
   output logic [15:0]       band_cnt,
   output logic              block,
   input  logic              blk_clr
);

   localparam int SW = $clog2(STALL_LIMIT + 1);

   bandState_e    state_q, state_d;
   logic [3:0]    gapCnt_q, gapCnt_d;
   logic [SW-1:0] stallCnt_q, stallCnt_d;
   logic          block_q, block_d;
   logic [31:0]   beatCnt_q;
   logic [15:0]   bandCnt_q;

   logic [DATA_W:0] headWord;
   logic            headValid;
   logic            memNonEmpty;
   logic            fifoFull;
   logic            xfer;

   assign out_stream_TVALID = (state_q == SEND);
   assign xfer              = out_stream_TVALID & out_stream_TREADY;
   assign out_stream_TDATA  = headWord[DATA_W-1:0];
   assign out_stream_TLAST  = headWord[DATA_W];
   assign ld_ready          = ~ap_rst & ~fifoFull;
   assign beat_cnt          = beatCnt_q;
   assign band_cnt          = bandCnt_q;
   assign block             = block_q;

   axis_band_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i         (ap_clk),
      .rst_i         (ap_rst),
      .push_i        (ld_valid & ld_ready),
      .pushData_i    ({ld_last, ld_data}),
      .pop_i         (xfer),
      .headData_o    (headWord),
      .headValid_o   (headValid),
      .memNonEmpty_o (memNonEmpty),
      .full_o        (fifoFull)
   );

   // State and gap-countdown registers.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q  <= IDLE;
         gapCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         gapCnt_q <= gapCnt_d;
      end
   end

   // Sequencing: leaving SEND after a pop relies on the memory behind the head.
   always_comb begin
      state_d  = state_q;
      gapCnt_d = gapCnt_q;
      unique case (state_q)
         IDLE: begin
            if (headValid) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (gap != 4'd0) begin
                  state_d  = GAP;
                  gapCnt_d = gap;
               end else if (memNonEmpty) begin
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gapCnt_q <= 4'd1) begin
               state_d = headValid ? SEND : IDLE;
            end else begin
               gapCnt_d = gapCnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Backpressure watchdog; a clear request wins over a coincident set.
   always_comb begin
      stallCnt_d = '0;
      block_d    = block_q;
      if (blk_clr) begin
         block_d = 1'b0;
      end else begin
         if (out_stream_TVALID && !out_stream_TREADY) begin
            stallCnt_d = (stallCnt_q == SW'(STALL_LIMIT)) ? stallCnt_q : stallCnt_q + 1'b1;
         end
         if (stallCnt_d == SW'(STALL_LIMIT)) begin
            block_d = 1'b1;
         end
      end
   end

   // Stall flag plus free-running beat and band counters.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         stallCnt_q <= '0;
         block_q    <= 1'b0;
         beatCnt_q  <= '0;
         bandCnt_q  <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         block_q    <= block_d;
         if (xfer) begin
            beatCnt_q <= beatCnt_q + 32'd1;
            if (out_stream_TLAST) begin
               bandCnt_q <= bandCnt_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_band_source.sv
// Directed bench for axis_band_source: latency, gaps, stall flag, full buffer, reset.
module tb_axis_band_source;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_data;
   logic        ld_last;
   logic [3:0]  gap;
   logic        tValid;
   logic        tReady;
   logic [31:0] tData;
   logic        tLast;
   logic [31:0] beat_cnt;
   logic [15:0] band_cnt;
   logic        block;
   logic        blk_clr;

   int checks   = 0;
   int failures = 0;

   logic [31:0] gotData [$];
   logic        gotLast [$];
   int          gotCyc  [$];
   int          cycNo = 0;

   axis_band_source dut (
      .ap_clk            (ap_clk),
      .ap_rst            (ap_rst),
      .ld_valid          (ld_valid),
      .ld_ready          (ld_ready),
      .ld_data           (ld_data),
      .ld_last           (ld_last),
      .gap               (gap),
      .out_stream_TVALID (tValid),
      .out_stream_TREADY (tReady),
      .out_stream_TDATA  (tData),
      .out_stream_TLAST  (tLast),
      .beat_cnt          (beat_cnt),
      .band_cnt          (band_cnt),
      .block             (block),
      .blk_clr           (blk_clr)
   );

   // Free-running clock.
   always #5 ap_clk = ~ap_clk;

   // Record every beat the next rising edge will hand over, sampled mid-cycle.
   always @(negedge ap_clk) begin
      cycNo++;
      if (!ap_rst && tValid && tReady) begin
         gotData.push_back(tData);
         gotLast.push_back(tLast);
         gotCyc.push_back(cycNo);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l);
      ld_valid = v;
      ld_data  = d;
      ld_last  = l;
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic clearMon();
      gotData.delete();
      gotLast.delete();
      gotCyc.delete();
   endtask

   // Directed sequence.
   initial begin
      ap_rst  = 1'b1;
      blk_clr = 1'b0;
      gap     = 4'd0;
      tReady  = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #3;
      checkOutput("rst_ld_ready", ld_ready, 1'b0);
      checkOutput("rst_tvalid", tValid, 1'b0);
      checkOutput("rst_tdata", tData, 32'h0);
      checkOutput("rst_tlast", tLast, 1'b0);
      checkOutput("rst_beat_cnt", beat_cnt, 32'd0);
      checkOutput("rst_band_cnt", band_cnt, 16'd0);
      checkOutput("rst_block", block, 1'b0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      tick();
      checkOutput("post_rst_ld_ready", ld_ready, 1'b1);
      checkOutput("post_rst_tvalid", tValid, 1'b0);

      $display("[TB] four-beat band, gap 0");
      tReady = 1'b1;
      clearMon();
      applyStimulus(1'b1, 32'h10, 1'b0); tick();
      checkOutput("lat_edge1_tvalid", tValid, 1'b0);
      applyStimulus(1'b1, 32'h11, 1'b0); tick();
      checkOutput("lat_edge2_tvalid", tValid, 1'b0);
      applyStimulus(1'b1, 32'h12, 1'b0); tick();
      checkOutput("lat_edge3_tvalid", tValid, 1'b1);
      checkOutput("lat_edge3_tdata", tData, 32'h10);
      applyStimulus(1'b1, 32'h13, 1'b1); tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (8) tick();
      checkOutput("band1_count", gotData.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("band1_data%0d", i), gotData[i], 32'h10 + i);
         checkOutput($sformatf("band1_last%0d", i), gotLast[i], (i == 3) ? 1'b1 : 1'b0);
      end
      checkOutput("band1_back_to_back", gotCyc[3] - gotCyc[0], 3);
      checkOutput("band1_beat_cnt", beat_cnt, 32'd4);
      checkOutput("band1_band_cnt", band_cnt, 16'd1);

      $display("[TB] two beats, gap 3");
      gap = 4'd3;
      clearMon();
      applyStimulus(1'b1, 32'h20, 1'b0); tick();
      applyStimulus(1'b1, 32'h21, 1'b1); tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (14) tick();
      checkOutput("gap_count", gotData.size(), 2);
      checkOutput("gap_data0", gotData[0], 32'h20);
      checkOutput("gap_data1", gotData[1], 32'h21);
      checkOutput("gap_last1", gotLast[1], 1'b1);
      checkOutput("gap_spacing", gotCyc[1] - gotCyc[0], 4);
      checkOutput("gap_beat_cnt", beat_cnt, 32'd6);
      checkOutput("gap_band_cnt", band_cnt, 16'd2);
      gap = 4'd0;

      $display("[TB] stall watchdog");
      tReady = 1'b0;
      applyStimulus(1'b1, 32'h30, 1'b1); tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (tValid) break;
         tick();
      end
      checkOutput("stall_tvalid_up", tValid, 1'b1);
      repeat (1023) tick();
      checkOutput("stall_1023_block", block, 1'b0);
      checkOutput("stall_1023_tvalid", tValid, 1'b1);
      checkOutput("stall_1023_tdata", tData, 32'h30);
      tick();
      checkOutput("stall_1024_block", block, 1'b1);
      tReady = 1'b1;
      repeat (3) tick();
      checkOutput("stall_sticky_block", block, 1'b1);
      checkOutput("stall_drained_tvalid", tValid, 1'b0);
      checkOutput("stall_beat_cnt", beat_cnt, 32'd7);
      checkOutput("stall_band_cnt", band_cnt, 16'd3);
      blk_clr = 1'b1; tick();
      blk_clr = 1'b0;
      checkOutput("stall_cleared_block", block, 1'b0);

      $display("[TB] full buffer with concurrent load and pop");
      tReady = 1'b0;
      clearMon();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 32'h40 + i, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 32'h50, 1'b0);
      checkOutput("full_ld_ready", ld_ready, 1'b0);
      tick();
      checkOutput("full_held_ld_ready", ld_ready, 1'b0);
      tReady = 1'b1;
      tick();
      checkOutput("after_pop_ld_ready", ld_ready, 1'b1);
      tick();
      checkOutput("load_pop_ld_ready", ld_ready, 1'b1);
      applyStimulus(1'b1, 32'h51, 1'b1);
      tReady = 1'b0;
      tick();
      checkOutput("refull_ld_ready", ld_ready, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      tReady = 1'b1;
      repeat (25) tick();
      checkOutput("full_count", gotData.size(), 18);
      for (int i = 0; i < 18; i++) begin
         checkOutput($sformatf("full_order%0d", i), gotData[i], (i < 16) ? 32'h40 + i : 32'h50 + (i - 16));
      end
      checkOutput("full_last15", gotLast[15], 1'b0);
      checkOutput("full_last17", gotLast[17], 1'b1);
      checkOutput("full_beat_cnt", beat_cnt, 32'd25);
      checkOutput("full_band_cnt", band_cnt, 16'd4);

      $display("[TB] reset mid-band");
      tReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h60 + i, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (2) tick();
      checkOutput("pre_rst_tvalid", tValid, 1'b1);
      #2;
      ap_rst = 1'b1;
      #1;
      checkOutput("mid_rst_tvalid", tValid, 1'b0);
      checkOutput("mid_rst_tdata", tData, 32'h0);
      checkOutput("mid_rst_beat_cnt", beat_cnt, 32'd0);
      checkOutput("mid_rst_band_cnt", band_cnt, 16'd0);
      checkOutput("mid_rst_ld_ready", ld_ready, 1'b0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      tReady = 1'b1;
      clearMon();
      repeat (10) tick();
      checkOutput("no_stale_beats", gotData.size(), 0);
      checkOutput("no_stale_tvalid", tValid, 1'b0);
      checkOutput("post_mid_rst_ld_ready", ld_ready, 1'b1);
      applyStimulus(1'b1, 32'h70, 1'b1); tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (6) tick();
      checkOutput("fresh_count", gotData.size(), 1);
      checkOutput("fresh_data", gotData[0], 32'h70);
      checkOutput("fresh_beat_cnt", beat_cnt, 32'd1);
      checkOutput("fresh_band_cnt", band_cnt, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
